// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter sequencer with a small
// return-address stack for call/return and a sticky overflow/underflow flag.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   En            advance enable (low = stall, all state holds)
//   op            000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, others INC
//   cond          branch condition (BRANCH only)
//   offset        signed branch displacement
//   target        absolute address for JUMP/CALL
//   pc            current program counter (registered)
//   tos           top-of-stack entry, 0 when the stack is empty
//   depth         number of valid stack entries
//   stack_full    depth == DEPTH
//   stack_empty   depth == 0
//   fault         sticky overflow/underflow flag
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       En,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic [WIDTH-1:0]           offset,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       fault
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] pc_inc;
  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    top_idx;
  logic             full;
  logic             empty;

  // Status decode from registered state only.
  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign pc_inc   = pc_q + WIDTH'(1);
  assign push_idx = IW'(depth_q);
  // Wraps when empty; every use is guarded by the empty flag.
  assign top_idx  = IW'(depth_q - DW'(1));

  // Next-state computation for pc, stack, depth and fault.
  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    fault_d = fault_q;
    if (En) begin
      case (op)
        OP_BRANCH: pc_d = cond ? (pc_q + offset) : pc_inc;
        OP_JUMP:   pc_d = target;
        OP_CALL: begin
          if (full) begin
            pc_d    = pc_inc;
            fault_d = 1'b1;
          end else begin
            stack_d[push_idx] = pc_inc;
            pc_d              = target;
            depth_d           = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d    = pc_inc;
            fault_d = 1'b1;
          end else begin
            // Popped entry is left in place; tos masks it once empty.
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default:   pc_d = pc_inc;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      stack_q <= '{default: '0};
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Top-of-stack view reads zero whenever the stack is empty.
  always_comb begin
    tos = '0;
    if (!empty) tos = stack_q[top_idx];
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// operations, all checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam int          MASK  = (1 << WIDTH) - 1;

  localparam int OP_INC = 0, OP_BRANCH = 1, OP_JUMP = 2, OP_CALL = 3, OP_RET = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             En;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] tos;
  logic [DW-1:0]    depth;
  logic             stack_full;
  logic             stack_empty;
  logic             fault;

  pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .En          (En),
    .op          (op),
    .cond        (cond),
    .offset      (offset),
    .target      (target),
    .pc          (pc),
    .tos         (tos),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_fault;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_fault = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input int o, input bit c,
                                     input int off, input int tgt);
    int inc;
    if (!en) return;
    inc = (m_pc + 1) & MASK;
    case (o)
      OP_BRANCH: m_pc = c ? ((m_pc + off) & MASK) : inc;
      OP_JUMP:   m_pc = tgt & MASK;
      OP_CALL: begin
        if (m_stk.size() == DEPTH) begin
          m_pc = inc;
          m_fault = 1'b1;
        end else begin
          m_stk.push_back(inc);
          m_pc = tgt & MASK;
        end
      end
      OP_RET: begin
        if (m_stk.size() == 0) begin
          m_pc = inc;
          m_fault = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
      default:   m_pc = inc;
    endcase
  endfunction

  task automatic check_all(input string tag);
    int exp_tos;
    exp_tos = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
    check_eq({tag, ".pc"},    32'(pc), m_pc);
    check_eq({tag, ".tos"},   32'(tos), exp_tos);
    check_eq({tag, ".depth"}, 32'(depth), m_stk.size());
    check_eq({tag, ".full"},  32'(stack_full), int'(m_stk.size() == DEPTH));
    check_eq({tag, ".empty"}, 32'(stack_empty), int'(m_stk.size() == 0));
    check_eq({tag, ".fault"}, 32'(fault), int'(m_fault));
  endtask

  // Drive one op from a negedge, let the posedge retire it, check at the next negedge.
  task automatic cycle(input string tag, input bit en, input int o,
                       input bit c = 1'b0, input int off = 0, input int tgt = 0);
    En     = en;
    op     = 3'(o);
    cond   = c;
    offset = 8'(off);
    target = 8'(tgt);
    @(posedge clk);
    model_step(en, o, c, off, tgt);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic sync_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; En = 1'b0; op = '0; cond = 1'b0; offset = '0; target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Async reset mid-run with pc=0x37, depth=2.
    cycle("pre_rst.c1", 1, OP_CALL, 0, 0, 'h10);
    cycle("pre_rst.c2", 1, OP_CALL, 0, 0, 'h37);
    check_eq("pre_rst.pc", 32'(pc), 'h37);
    #1 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    check_eq("async_rst.pc", 32'(pc), 'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle("inc", 1, OP_INC);
    check_eq("inc3.pc", 32'(pc), 'h03);

    // Stall holds everything while a JUMP is presented.
    cycle("stall.set", 1, OP_JUMP, 0, 0, 'h10);
    repeat (4) cycle("stall", 0, OP_JUMP, 0, 0, 'h80);
    check_eq("stall.pc", 32'(pc), 'h10);
    cycle("unstall", 1, OP_JUMP, 0, 0, 'h80);
    check_eq("unstall.pc", 32'(pc), 'h80);

    // Branch and wrap.
    cycle("br.set", 1, OP_JUMP, 0, 0, 'h20);
    cycle("br.taken", 1, OP_BRANCH, 1, 'hF0);
    check_eq("br.taken.pc", 32'(pc), 'h10);
    cycle("br.not", 1, OP_BRANCH, 0, 'hF0);
    check_eq("br.not.pc", 32'(pc), 'h11);
    cycle("wrap.set", 1, OP_JUMP, 0, 0, 'hFF);
    cycle("wrap", 1, OP_INC);
    check_eq("wrap.pc", 32'(pc), 'h00);

    // Nested calls.
    cycle("nest.set", 1, OP_JUMP, 0, 0, 'h05);
    cycle("nest.call1", 1, OP_CALL, 0, 0, 'h40);
    check_eq("nest.call1.tos", 32'(tos), 'h06);
    cycle("nest.call2", 1, OP_CALL, 0, 0, 'h60);
    check_eq("nest.call2.tos", 32'(tos), 'h41);
    cycle("nest.ret1", 1, OP_RET);
    check_eq("nest.ret1.pc", 32'(pc), 'h41);
    cycle("nest.ret2", 1, OP_RET);
    check_eq("nest.ret2.pc", 32'(pc), 'h06);
    check_eq("nest.ret2.tos", 32'(tos), 'h00);

    // Overflow, then sticky fault.
    for (int i = 0; i < 4; i++) cycle("ovf.fill", 1, OP_CALL, 0, 0, 'h90 + i);
    cycle("ovf.set", 1, OP_JUMP, 0, 0, 'h33);
    cycle("ovf.call", 1, OP_CALL, 0, 0, 'hA0);
    check_eq("ovf.pc", 32'(pc), 'h34);
    check_eq("ovf.full", 32'(stack_full), 1);
    check_eq("ovf.fault", 32'(fault), 1);
    cycle("ovf.inc", 1, OP_INC);
    cycle("ovf.ret", 1, OP_RET);
    check_eq("ovf.sticky", 32'(fault), 1);
    sync_reset("ovf.clr");

    // Underflow and reserved opcode.
    cycle("unf.set", 1, OP_JUMP, 0, 0, 'h50);
    cycle("unf.ret", 1, OP_RET);
    check_eq("unf.pc", 32'(pc), 'h51);
    check_eq("unf.fault", 32'(fault), 1);
    cycle("rsv", 1, 6);
    check_eq("rsv.pc", 32'(pc), 'h52);
    sync_reset("rand.start");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        sync_reset("rand.rst");
      end else begin
        cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
              1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
